// File: rtl/sha256_block_engine_if.sv
// Word-stream handshake into the SHA-256 block engine.
// The producer drives the message words; the engine drives word_ready.
interface sha256_block_engine_if;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_in;
    logic        block_first;

    modport master (output word_valid, output word_in, output block_first, input word_ready);
    modport slave  (input word_valid, input word_in, input block_first, output word_ready);
endinterface

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: loads 16 words, runs 64 rounds one per clock,
// then folds the working variables into the chaining value H.
module sha256_block_engine #(
    parameter logic [255:0] INIT_H =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                        clk,
    input  logic                        rst,
    sha256_block_engine_if.slave        win,
    output logic                        busy,
    output logic                        digest_valid,
    output logic [255:0]                digest
);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {StLoad, StRound, StUpdate} state_e;

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    state_e         state_q, state_d;
    logic [3:0]     wcnt_q;
    logic [5:0]     rnd_q;
    logic           first_q;
    logic [255:0]   hash_q;
    logic [255:0]   digest_q;
    logic           dv_q;
    logic [31:0]    w_q [16];
    logic [31:0]    a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;

    logic           xfer;
    logic [255:0]   chain;
    logic [255:0]   hash_sum;
    logic [31:0]    t1, t2, w_new;

    assign xfer         = win.word_valid && (state_q == StLoad);
    assign chain        = first_q ? INIT_H : hash_q;
    assign digest       = digest_q;
    assign digest_valid = dv_q;

    always_comb begin
        t1    = h_q + big_s1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + K[rnd_q] + w_q[0];
        t2    = big_s0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
        // w_q[k] holds W[t+k] during round t
        w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];
        hash_sum = {hash_q[255:224] + a_q, hash_q[223:192] + b_q,
                    hash_q[191:160] + c_q, hash_q[159:128] + d_q,
                    hash_q[127:96]  + e_q, hash_q[95:64]   + f_q,
                    hash_q[63:32]   + g_q, hash_q[31:0]    + h_q};
    end

    always_comb begin
        state_d        = state_q;
        win.word_ready = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            StLoad: begin
                win.word_ready = 1'b1;
                if (xfer && (wcnt_q == 4'd15)) state_d = StRound;
            end
            StRound: begin
                busy = 1'b1;
                if (rnd_q == 6'd63) state_d = StUpdate;
            end
            StUpdate: begin
                busy    = 1'b1;
                state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StLoad;
            wcnt_q   <= 4'd0;
            rnd_q    <= 6'd0;
            first_q  <= 1'b0;
            hash_q   <= INIT_H;
            digest_q <= INIT_H;
            dv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= (state_q == StUpdate);
            if (xfer) begin
                wcnt_q <= wcnt_q + 4'd1;
                if (wcnt_q == 4'd0) first_q <= win.block_first;
                if (wcnt_q == 4'd15) begin
                    hash_q <= chain;
                    rnd_q  <= 6'd0;
                end
            end
            if (state_q == StRound) rnd_q <= rnd_q + 6'd1;
            if (state_q == StUpdate) begin
                hash_q   <= hash_sum;
                digest_q <= hash_sum;
            end
        end
    end

    // Message schedule and working variables need no reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= win.word_in;
            if (wcnt_q == 4'd15) {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= chain;
        end else if (state_q == StRound) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= w_new;
            h_q <= g_q;
            g_q <= f_q;
            f_q <= e_q;
            e_q <= d_q + t1;
            d_q <= c_q;
            c_q <= b_q;
            b_q <= a_q;
            a_q <= t1 + t2;
        end
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine using known SHA-256 vectors.
module tb_sha256_block_engine;

    localparam logic [255:0] INIT_H =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_MID =
        256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] D_TWO =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef logic [31:0] blk_t [16];

    logic         clk = 1'b0;
    logic         rst;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;
    int           n_checks = 0;
    int           n_fail   = 0;
    blk_t         blk_empty, blk_abc, blk_m1, blk_m2;

    always #5 clk = ~clk;

    sha256_block_engine_if wif();

    sha256_block_engine dut (
        .clk          (clk),
        .rst          (rst),
        .win          (wif),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    // Ends #1 after the edge that transfers word 15, with word_valid dropped
    task automatic send_block(input blk_t b, input logic first, input bit gaps,
                              output int cycles);
        int   idx;
        logic xfer;
        idx    = 0;
        cycles = 0;
        while (idx < 16 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            wif.word_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wif.word_in     = b[idx];
            wif.block_first = (idx == 0) ? first : 1'($urandom_range(0, 1));
            xfer = wif.word_valid && wif.word_ready;
            @(posedge clk);
            if (xfer) idx++;
        end
        #1;
        wif.word_valid = 1'b0;
        n_checks++;
        if (idx !== 16) begin
            n_fail++;
            $display("FAIL send_block: transferred %0d words, required 16", idx);
        end
    endtask

    task automatic wait_digest(input bit garbage, output int lat, output int rlow);
        lat  = 0;
        rlow = 0;
        if (!wif.word_ready) rlow++;
        while (!digest_valid && lat < 200) begin
            if (garbage) begin
                wif.word_valid  = 1'($urandom_range(0, 1));
                wif.word_in     = $urandom;
                wif.block_first = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
            if (!wif.word_ready) rlow++;
        end
        wif.word_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        wif.word_valid = 1'b0;
        wif.word_in    = 32'd0;
        wif.block_first = 1'b0;
        #12;
        n_checks += 3;
        if (digest !== INIT_H) begin
            n_fail++; $display("FAIL reset_digest: got %h required %h", digest, INIT_H);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        if (digest_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_dv: got %b required 0", digest_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (wif.word_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", wif.word_ready);
        end
    endtask

    task automatic test_empty();
        int cyc, lat, rlow;
        send_block(blk_empty, 1'b1, 1'b0, cyc);
        wait_digest(1'b0, lat, rlow);
        n_checks += 3;
        if (lat !== 65) begin
            n_fail++; $display("FAIL empty_latency: got %0d required 65", lat);
        end
        if (rlow !== 65) begin
            n_fail++; $display("FAIL empty_ready_low: got %0d cycles required 65", rlow);
        end
        if (digest !== D_EMPTY) begin
            n_fail++; $display("FAIL empty_digest: got %h required %h", digest, D_EMPTY);
        end
        @(posedge clk);
        #1;
        n_checks += 2;
        if (digest_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_dv_pulse: got %b required 0", digest_valid);
        end
        if (digest !== D_EMPTY) begin
            n_fail++; $display("FAIL empty_digest_hold: got %h required %h", digest, D_EMPTY);
        end
    endtask

    task automatic test_abc_ignored_input();
        int cyc, lat, rlow;
        send_block(blk_abc, 1'b1, 1'b0, cyc);
        wait_digest(1'b1, lat, rlow);
        n_checks += 3;
        if (lat !== 65) begin
            n_fail++; $display("FAIL abc_latency: got %0d required 65", lat);
        end
        if (rlow !== 65) begin
            n_fail++; $display("FAIL abc_ready_low: got %0d cycles required 65", rlow);
        end
        if (digest !== D_ABC) begin
            n_fail++; $display("FAIL abc_digest: got %h required %h", digest, D_ABC);
        end
    endtask

    task automatic test_two_block(input bit gaps);
        int cyc, lat, rlow;
        send_block(blk_m1, 1'b1, gaps, cyc);
        wait_digest(1'b0, lat, rlow);
        n_checks += 2;
        if (digest_valid !== 1'b1) begin
            n_fail++; $display("FAIL two_block_mid_dv (gaps=%0d): got %b required 1",
                               gaps, digest_valid);
        end
        if (digest !== D_MID) begin
            n_fail++; $display("FAIL two_block_mid (gaps=%0d): got %h required %h",
                               gaps, digest, D_MID);
        end
        send_block(blk_m2, 1'b0, gaps, cyc);
        wait_digest(1'b0, lat, rlow);
        n_checks += 2;
        if (lat !== 65) begin
            n_fail++; $display("FAIL two_block_latency (gaps=%0d): got %0d required 65",
                               gaps, lat);
        end
        if (digest !== D_TWO) begin
            n_fail++; $display("FAIL two_block_digest (gaps=%0d): got %h required %h",
                               gaps, digest, D_TWO);
        end
    endtask

    // Entered in the digest_valid cycle of the previous message
    task automatic test_back_to_back();
        int cyc, lat, rlow;
        n_checks += 2;
        if (digest_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_dv: got %b required 1", digest_valid);
        end
        if (wif.word_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b required 1", wif.word_ready);
        end
        send_block(blk_abc, 1'b1, 1'b0, cyc);
        n_checks++;
        if (cyc !== 16) begin
            n_fail++; $display("FAIL b2b_load_cycles: got %0d required 16", cyc);
        end
        wait_digest(1'b0, lat, rlow);
        n_checks++;
        if (digest !== D_ABC) begin
            n_fail++; $display("FAIL b2b_digest: got %h required %h", digest, D_ABC);
        end
    endtask

    task automatic test_reset_mid_round();
        int cyc, lat, rlow, seen;
        send_block(blk_abc, 1'b1, 1'b0, cyc);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (digest !== INIT_H) begin
            n_fail++; $display("FAIL midrst_digest: got %h required %h", digest, INIT_H);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b required 0", busy);
        end
        if (wif.word_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ready: got %b required 1", wif.word_ready);
        end
        if (digest_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_dv: got %b required 0", digest_valid);
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (digest_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midrst_no_dv: got %0d pulses required 0", seen);
        end
        send_block(blk_abc, 1'b1, 1'b0, cyc);
        wait_digest(1'b0, lat, rlow);
        n_checks += 2;
        if (lat !== 65) begin
            n_fail++; $display("FAIL midrst_abc_latency: got %0d required 65", lat);
        end
        if (digest !== D_ABC) begin
            n_fail++; $display("FAIL midrst_abc_digest: got %h required %h", digest, D_ABC);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_empty[i] = 32'd0;
            blk_abc[i]   = 32'd0;
            blk_m1[i]    = 32'd0;
            blk_m2[i]    = 32'd0;
        end
        blk_empty[0] = 32'h80000000;
        blk_abc[0]   = 32'h61626380;
        blk_abc[15]  = 32'h00000018;
        blk_m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_m2[15] = 32'h000001c0;

        test_reset();
        test_empty();
        test_abc_ignored_input();
        test_two_block(1'b0);
        test_two_block(1'b1);
        test_back_to_back();
        test_reset_mid_round();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
